// File: rtl/fast_corner_scan.sv
// fast_corner_scan: FAST corner stage. Raster-scans the filtered image in the
// conv SRAM, fetches the centre and the 16-point radius-3 circle for every
// interior pixel, and writes one score per pixel to the FAST SRAM.
// Optional build macro FAST_SCORE_EN: when defined, the score is the
// saturated sum of (|p-c| - t) over the winning arc mask; when undefined,
// a corner scores all ones and a non-corner scores 0.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start; configuration latched on acceptance
// S_SCAN  | classify current pixel as border or interior
// S_FETCH | 17 reads: centre, then circle points 0..15
// S_WAIT  | capture the final circle sample
// S_EVAL  | build bright/dark masks, detect the arc, form the score
// S_WRITE | write score for current pixel, advance raster position
// S_DONE  | one-cycle end-of-frame pulse
module fast_corner_scan #(
    parameter int X_MAX       = 400,
    parameter int Y_MAX       = 400,
    parameter int PIXEL_DEPTH = 8,
    parameter int SCORE_DEPTH = 12
) (
    input  logic                            clk,
    input  logic                            n_rst,
    input  logic                            start,
    input  logic [PIXEL_DEPTH-1:0]          threshold,
    input  logic [4:0]                      arc_len,
    input  logic [$clog2(X_MAX):0]          max_x,
    input  logic [$clog2(Y_MAX):0]          max_y,
    output logic [$clog2(X_MAX):0]          x_addr_rd,
    output logic [$clog2(Y_MAX):0]          y_addr_rd,
    output logic                            ren_rd,
    input  logic [PIXEL_DEPTH-1:0]          rdat_rd,
    output logic [$clog2(X_MAX):0]          x_addr_wr,
    output logic [$clog2(Y_MAX):0]          y_addr_wr,
    output logic                            wen_wr,
    output logic [SCORE_DEPTH-1:0]          wdat_wr,
    output logic                            busy,
    output logic                            done,
    output logic [$clog2(X_MAX*Y_MAX):0]    corner_count
);

    localparam int XW = $clog2(X_MAX) + 1;
    localparam int YW = $clog2(Y_MAX) + 1;
    localparam int CW = $clog2(X_MAX*Y_MAX) + 1;
    localparam int PW = PIXEL_DEPTH;

    // Circle offsets, index 0 at the top, going clockwise.
    localparam int DXT [0:15] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
    localparam int DYT [0:15] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_FETCH, S_WAIT, S_EVAL, S_WRITE, S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [XW-1:0]          x_q, x_d, mx_q, mx_d;
    logic [YW-1:0]          y_q, y_d, my_q, my_d;
    logic [PW-1:0]          thr_q, thr_d;
    logic [4:0]             arc_q, arc_d;
    logic [4:0]             rd_cnt_q, rd_cnt_d;
    logic [PW-1:0]          cen_q, cen_d;
    logic [PW-1:0]          ring_q [16];
    logic [PW-1:0]          ring_d [16];
    logic [SCORE_DEPTH-1:0] score_q, score_d;
    logic [CW-1:0]          count_q, count_d;
    logic [XW-1:0]          x_rdh_q, x_rdh_d, x_wrh_q, x_wrh_d;
    logic [YW-1:0]          y_rdh_q, y_rdh_d, y_wrh_q, y_wrh_d;

    logic [XW-1:0]          rd_x;
    logic [YW-1:0]          rd_y;
    logic [3:0]             ring_i;
    logic                   border;
    logic [15:0]            bright, dark;
    logic                   is_b, is_d;
    logic [SCORE_DEPTH-1:0] score_eval;

    // True when m holds a run of at least len ones, with bit 15 adjacent to bit 0.
    function automatic logic has_run(input logic [15:0] m, input logic [4:0] len);
        logic hit;
        logic all_set;
        hit = 1'b0;
        for (int s = 0; s < 16; s++) begin
            all_set = 1'b1;
            for (int k = 0; k < 16; k++) begin
                if ((5'(k) < len) && !m[4'(s + k)]) all_set = 1'b0;
            end
            hit = hit | all_set;
        end
        return hit;
    endfunction

    // Read address for the current fetch step: centre first, then circle points.
    always_comb begin
        ring_i = 4'(rd_cnt_q - 5'd1);
        rd_x   = x_q;
        rd_y   = y_q;
        if (rd_cnt_q != 5'd0) begin
            rd_x = x_q + XW'(DXT[ring_i]);
            rd_y = y_q + YW'(DYT[ring_i]);
        end
    end

    // Border classification; tiny frames have no interior at all.
    always_comb begin
        border = (mx_q < XW'(6)) || (my_q < YW'(6)) ||
                 (x_q < XW'(3)) || (y_q < YW'(3)) ||
                 (x_q > mx_q - XW'(3)) || (y_q > my_q - YW'(3));
    end

    // Bright/dark masks in PW+1 bits, arc detection and score formation.
    always_comb begin
        logic [PW:0] c9, t9, p9;
        bright = '0;
        dark   = '0;
        c9 = {1'b0, cen_q};
        t9 = {1'b0, thr_q};
        for (int i = 0; i < 16; i++) begin
            p9 = {1'b0, ring_q[i]};
            bright[i] = p9 > (c9 + t9);
            dark[i]   = (p9 + t9) < c9;
        end
        is_b = has_run(bright, arc_q);
        is_d = has_run(dark, arc_q);
`ifdef FAST_SCORE_EN
        begin
            logic [PW+4:0] sum;
            logic [15:0]   win;
            logic [PW:0]   diff;
            sum = '0;
            win = is_b ? bright : (is_d ? dark : 16'h0000);
            for (int i = 0; i < 16; i++) begin
                p9   = {1'b0, ring_q[i]};
                diff = is_b ? (p9 - c9 - t9) : (c9 - p9 - t9);
                if (win[i]) sum = sum + (PW+5)'(diff);
            end
            score_eval = (|(sum >> SCORE_DEPTH)) ? '1 : SCORE_DEPTH'(sum);
        end
`else
        score_eval = (is_b || is_d) ? '1 : '0;
`endif
    end

    // Next-state and datapath updates for the scan controller.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        mx_d     = mx_q;
        my_d     = my_q;
        thr_d    = thr_q;
        arc_d    = arc_q;
        rd_cnt_d = rd_cnt_q;
        cen_d    = cen_q;
        ring_d   = ring_q;
        score_d  = score_q;
        count_d  = count_q;
        x_rdh_d  = x_rdh_q;
        y_rdh_d  = y_rdh_q;
        x_wrh_d  = x_wrh_q;
        y_wrh_d  = y_wrh_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    thr_d   = threshold;
                    arc_d   = ((arc_len >= 5'd9) && (arc_len <= 5'd16)) ? arc_len : 5'd9;
                    mx_d    = max_x;
                    my_d    = max_y;
                    x_d     = '0;
                    y_d     = '0;
                    count_d = '0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (border) begin
                    score_d = '0;
                    state_d = S_WRITE;
                end else begin
                    rd_cnt_d = 5'd0;
                    state_d  = S_FETCH;
                end
            end
            S_FETCH: begin
                // Data for the previous read arrives one cycle late.
                if (rd_cnt_q == 5'd1) cen_d = rdat_rd;
                else if (rd_cnt_q >= 5'd2) ring_d[4'(rd_cnt_q - 5'd2)] = rdat_rd;
                x_rdh_d = rd_x;
                y_rdh_d = rd_y;
                if (rd_cnt_q == 5'd16) state_d = S_WAIT;
                else rd_cnt_d = rd_cnt_q + 5'd1;
            end
            S_WAIT: begin
                ring_d[15] = rdat_rd;
                state_d    = S_EVAL;
            end
            S_EVAL: begin
                score_d = score_eval;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                x_wrh_d = x_q;
                y_wrh_d = y_q;
                if (score_q != '0) count_d = count_q + CW'(1);
                if (x_q == mx_q) begin
                    x_d = '0;
                    if (y_q == my_q) state_d = S_DONE;
                    else begin
                        y_d     = y_q + YW'(1);
                        state_d = S_SCAN;
                    end
                end else begin
                    x_d     = x_q + XW'(1);
                    state_d = S_SCAN;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            mx_q     <= '0;
            my_q     <= '0;
            thr_q    <= '0;
            arc_q    <= 5'd9;
            rd_cnt_q <= '0;
            cen_q    <= '0;
            ring_q   <= '{default: '0};
            score_q  <= '0;
            count_q  <= '0;
            x_rdh_q  <= '0;
            y_rdh_q  <= '0;
            x_wrh_q  <= '0;
            y_wrh_q  <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            mx_q     <= mx_d;
            my_q     <= my_d;
            thr_q    <= thr_d;
            arc_q    <= arc_d;
            rd_cnt_q <= rd_cnt_d;
            cen_q    <= cen_d;
            ring_q   <= ring_d;
            score_q  <= score_d;
            count_q  <= count_d;
            x_rdh_q  <= x_rdh_d;
            y_rdh_q  <= y_rdh_d;
            x_wrh_q  <= x_wrh_d;
            y_wrh_q  <= y_wrh_d;
        end
    end

    // Addresses follow the live value while enabled and hold otherwise.
    assign ren_rd       = (state_q == S_FETCH);
    assign x_addr_rd    = ren_rd ? rd_x : x_rdh_q;
    assign y_addr_rd    = ren_rd ? rd_y : y_rdh_q;
    assign wen_wr       = (state_q == S_WRITE);
    assign x_addr_wr    = wen_wr ? x_q : x_wrh_q;
    assign y_addr_wr    = wen_wr ? y_q : y_wrh_q;
    assign wdat_wr      = score_q;
    assign busy         = (state_q == S_SCAN) || (state_q == S_FETCH) || (state_q == S_WAIT) ||
                          (state_q == S_EVAL) || (state_q == S_WRITE);
    assign done         = (state_q == S_DONE);
    assign corner_count = count_q;

endmodule

// File: tb/tb_fast_corner_scan.sv
// Testbench for fast_corner_scan: directed and random frames checked against
// an arithmetic reference model of the FAST score.
module tb_fast_corner_scan;

    localparam int SD = 12;

    logic        clk = 1'b0;
    logic        n_rst, start;
    logic [7:0]  threshold, rdat;
    logic [4:0]  arc_len;
    logic [9:0]  max_x, max_y;
    logic [9:0]  x_addr_rd, y_addr_rd, x_addr_wr, y_addr_wr;
    logic        ren_rd, wen_wr, busy, done;
    logic [11:0] wdat_wr;
    logic [18:0] corner_count;
    logic [9:0]  x_rd10, y_rd10, x_wr10, y_wr10;
    logic        ren10, wen10, busy10, done10;
    logic [9:0]  wdat10;
    logic [18:0] cc10;

    int img   [0:31][0:31];
    int got   [0:31][0:31];
    int got10 [0:31][0:31];
    int DX [16] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
    int DY [16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};
    int errors = 0;
    int checks = 0;
    int cur_mx, cur_my, cur_t, cur_al;

    always #5 clk = ~clk;

    fast_corner_scan dut (
        .clk(clk), .n_rst(n_rst), .start(start), .threshold(threshold), .arc_len(arc_len),
        .max_x(max_x), .max_y(max_y), .x_addr_rd(x_addr_rd), .y_addr_rd(y_addr_rd),
        .ren_rd(ren_rd), .rdat_rd(rdat), .x_addr_wr(x_addr_wr), .y_addr_wr(y_addr_wr),
        .wen_wr(wen_wr), .wdat_wr(wdat_wr), .busy(busy), .done(done),
        .corner_count(corner_count)
    );

    fast_corner_scan #(.SCORE_DEPTH(10)) dut10 (
        .clk(clk), .n_rst(n_rst), .start(start), .threshold(threshold), .arc_len(arc_len),
        .max_x(max_x), .max_y(max_y), .x_addr_rd(x_rd10), .y_addr_rd(y_rd10),
        .ren_rd(ren10), .rdat_rd(rdat), .x_addr_wr(x_wr10), .y_addr_wr(y_wr10),
        .wen_wr(wen10), .wdat_wr(wdat10), .busy(busy10), .done(done10),
        .corner_count(cc10)
    );

    // Conv SRAM model: one-cycle read latency.
    always @(posedge clk) begin
        if (ren_rd) rdat <= 8'(img[y_addr_rd[4:0]][x_addr_rd[4:0]]);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int maxrun(input bit m [16]);
        int best;
        best = 0;
        for (int s = 0; s < 16; s++) begin
            int n;
            n = 0;
            while (n < 16 && m[(s + n) % 16]) n++;
            if (n > best) best = n;
        end
        return best;
    endfunction

    function automatic int model_score(input int x, input int y, input int sd);
        int c, L, rb, rk, sum;
        int p [16];
        bit b [16];
        bit d [16];
        if (cur_mx < 6 || cur_my < 6 || x < 3 || y < 3 || x > cur_mx - 3 || y > cur_my - 3)
            return 0;
        L = (cur_al >= 9 && cur_al <= 16) ? cur_al : 9;
        c = img[y][x];
        for (int i = 0; i < 16; i++) begin
            p[i] = img[y + DY[i]][x + DX[i]];
            b[i] = (p[i] > c + cur_t);
            d[i] = (p[i] + cur_t < c);
        end
        rb = maxrun(b);
        rk = maxrun(d);
        if (rb < L && rk < L) return 0;
`ifdef FAST_SCORE_EN
        sum = 0;
        for (int i = 0; i < 16; i++) begin
            if (rb >= L ? b[i] : d[i]) sum += ((p[i] > c) ? p[i] - c : c - p[i]) - cur_t;
        end
        return (sum > (1 << sd) - 1) ? (1 << sd) - 1 : sum;
`else
        sum = 0;
        return (1 << sd) - 1 + sum;
`endif
    endfunction

    task automatic fill(input int v);
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 32; x++) img[y][x] = v;
    endtask

    // Runs one frame from IDLE; must be called at a falling edge.
    task automatic run_frame(input string nm, input int mx, input int my, input int t,
                             input int al, input bit hold);
        int wx, wy, nwr, nz, bcy, ndone, extra, total, intr, es, es10;
        wx = 0; wy = 0; nwr = 0; nz = 0; bcy = 0; ndone = 0; extra = 0;
        cur_mx = mx; cur_my = my; cur_t = t; cur_al = al;
        total = (mx + 1) * (my + 1);
        intr  = (mx >= 6 && my >= 6) ? (mx - 5) * (my - 5) : 0;
        threshold = 8'(t); arc_len = 5'(al); max_x = 10'(mx); max_y = 10'(my);
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        for (int cyc = 0; cyc < 6000 && ndone == 0; cyc++) begin
            if (hold && cyc == 40) max_x = 10'((mx > 10) ? mx - 4 : mx + 4);
            if (busy) bcy++;
            if (wen_wr) begin
                if (nwr < total) begin
                    es   = model_score(wx, wy, SD);
                    es10 = model_score(wx, wy, 10);
                    chk($sformatf("%s waddr", nm), 32'(y_addr_wr) * 1024 + 32'(x_addr_wr),
                        32'(wy * 1024 + wx));
                    chk($sformatf("%s wdat(%0d,%0d)", nm, wx, wy), 32'(wdat_wr), 32'(es));
                    chk($sformatf("%s wdat10(%0d,%0d)", nm, wx, wy), 32'(wdat10), 32'(es10));
                    got[wy][wx]   = int'(wdat_wr);
                    got10[wy][wx] = int'(wdat10);
                    if (es != 0) nz++;
                    if (wx == mx) begin wx = 0; wy++; end
                    else wx++;
                end
                nwr++;
            end
            if (done) begin ndone++; start = 1'b0; end
            @(negedge clk);
        end
        start = 1'b0;
        chk($sformatf("%s done_pulse", nm), 32'(ndone), 32'd1);
        chk($sformatf("%s writes", nm), 32'(nwr), 32'(total));
        chk($sformatf("%s busy_cycles", nm), 32'(bcy), 32'(21 * intr + 2 * (total - intr)));
        chk($sformatf("%s corner_count", nm), 32'(corner_count), 32'(nz));
        repeat (3) begin
            if (done || busy) extra++;
            @(negedge clk);
        end
        chk($sformatf("%s idle_after", nm), 32'(extra), 32'd0);
        max_x = 10'(mx);
    endtask

    initial begin
        int found, prev_ren, mx, my;
        n_rst = 1'b0; start = 1'b0; threshold = '0; arc_len = '0; max_x = '0; max_y = '0;
        fill(0);
        repeat (3) @(negedge clk);
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        chk("rst ren", 32'(ren_rd), 0);
        chk("rst wen", 32'(wen_wr), 0);
        chk("rst xrd", 32'(x_addr_rd), 0);
        chk("rst yrd", 32'(y_addr_rd), 0);
        chk("rst xwr", 32'(x_addr_wr), 0);
        chk("rst ywr", 32'(y_addr_wr), 0);
        chk("rst wdat", 32'(wdat_wr), 0);
        chk("rst count", 32'(corner_count), 0);
        n_rst = 1'b1;
        @(negedge clk);

        // Flat image: no corners anywhere.
        fill(80);
        run_frame("flat", 19, 19, 10, 9, 1'b0);

        // Single bright spot over a dark background.
        fill(50); img[10][10] = 200;
        run_frame("blob", 19, 19, 20, 9, 1'b0);
`ifdef FAST_SCORE_EN
        chk("blob score", 32'(got[10][10]), 32'd2080);
`else
        chk("blob score", 32'(got[10][10]), 32'd4095);
`endif
        chk("blob count", 32'(corner_count), 32'd1);

        // Nine-point arc that wraps through index 0.
        fill(100);
        for (int i = 0; i < 16; i++)
            if (i >= 12 || i <= 4) img[10 + DY[i]][10 + DX[i]] = 160;
        run_frame("wrap9", 19, 19, 20, 9, 1'b0);
`ifdef FAST_SCORE_EN
        chk("wrap9 score", 32'(got[10][10]), 32'd360);
`else
        chk("wrap9 score", 32'(got[10][10]), 32'd4095);
`endif
        run_frame("wrap12", 19, 19, 20, 12, 1'b0);
        chk("wrap12 score", 32'(got[10][10]), 32'd0);

        // Full bright ring: saturates the narrow-score instance.
        fill(0);
        for (int i = 0; i < 16; i++) img[10 + DY[i]][10 + DX[i]] = 255;
        run_frame("ring", 19, 19, 0, 16, 1'b0);
        chk("ring score10", 32'(got10[10][10]), 32'd1023);
`ifdef FAST_SCORE_EN
        chk("ring score", 32'(got[10][10]), 32'd4080);
`else
        chk("ring score", 32'(got[10][10]), 32'd4095);
`endif

        // Reset pulse during the fetch of pixel (5,5) after a corner has been counted.
        fill(50); img[3][8] = 200;
        threshold = 8'd20; arc_len = 5'd9; max_x = 10'd19; max_y = 10'd19;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0; prev_ren = 1;
        for (int cyc = 0; cyc < 3000 && found == 0; cyc++) begin
            if (ren_rd && !prev_ren && x_addr_rd == 10'd5 && y_addr_rd == 10'd5) found = 1;
            else begin
                prev_ren = int'(ren_rd);
                @(negedge clk);
            end
        end
        chk("midrst reached", 32'(found), 32'd1);
        chk("midrst count_before", 32'(corner_count), 32'd1);
        n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        chk("midrst busy", 32'(busy), 0);
        chk("midrst ren", 32'(ren_rd), 0);
        chk("midrst wen", 32'(wen_wr), 0);
        chk("midrst count", 32'(corner_count), 0);
        @(negedge clk);
        chk("midrst stays idle", 32'(busy | ren_rd | wen_wr), 0);
        run_frame("rescan", 19, 19, 20, 9, 1'b0);

        // start held through the frame while max_x changes.
        fill(50); img[6][7] = 220;
        run_frame("hold", 15, 12, 15, 9, 1'b1);

        // Random frames, including sizes with no interior.
        for (int r = 0; r < 4; r++) begin
            mx = int'($urandom_range(4, 19));
            my = int'($urandom_range(4, 19));
            for (int y = 0; y < 32; y++)
                for (int x = 0; x < 32; x++)
                    img[y][x] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(150, 255))
                                                            : int'($urandom_range(40, 70));
            run_frame($sformatf("rand%0d", r), mx, my, int'($urandom_range(0, 40)),
                      int'($urandom_range(0, 31)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fast_corner_scan.md
Name: fast_corner_scan

Overview:
Next-generation FAST corner stage. It raster-scans the Gaussian-filtered image held in the conv SRAM and, for every pixel, fetches the centre and the 16-point radius-3 Bresenham circle. It applies a runtime threshold and a runtime contiguous-arc length (9..16), then writes one score per pixel to the FAST SRAM. It sits after GaussianConv inside orb_fast and is started once conv_done is seen.

Parameters:
X_MAX, 400, maximum image width; sets the address width $clog2(X_MAX)+1
Y_MAX, 400, maximum image height; sets the address width $clog2(Y_MAX)+1
PIXEL_DEPTH, 8, input pixel width
SCORE_DEPTH, 12, output score width (saturating)

Ports:
clk  input  1  system clock
n_rst  input  1  synchronous active-low reset
start  input  1  begin a frame; sampled only in IDLE
threshold  input  PIXEL_DEPTH  intensity threshold t
arc_len  input  5  required contiguous arc length; values outside 9..16 are treated as 9
max_x  input  $clog2(X_MAX)+1  last valid column index (inclusive)
max_y  input  $clog2(Y_MAX)+1  last valid row index (inclusive)
x_addr_rd  output  $clog2(X_MAX)+1  conv SRAM read column
y_addr_rd  output  $clog2(Y_MAX)+1  conv SRAM read row
ren_rd  output  1  conv SRAM read enable; rdat_rd is valid on the next cycle
rdat_rd  input  PIXEL_DEPTH  conv SRAM read data
x_addr_wr  output  $clog2(X_MAX)+1  FAST SRAM write column
y_addr_wr  output  $clog2(Y_MAX)+1  FAST SRAM write row
wen_wr  output  1  FAST SRAM write enable
wdat_wr  output  SCORE_DEPTH  score written
busy  output  1  frame in progress
done  output  1  one-cycle pulse at end of frame
corner_count  output  $clog2(X_MAX*Y_MAX)+1  count of nonzero scores in the current or last frame

Behaviour:
- Reset (sync, n_rst=0): state IDLE; all outputs 0, including corner_count and addresses. Reset mid-frame aborts the frame immediately; no further ren_rd or wen_wr pulses occur.
- Latching: threshold, arc_len, max_x and max_y are latched when start is accepted. start is ignored while busy or in DONE.
- FSM states: IDLE -> SCAN -> (FETCH -> WAIT -> EVAL ->) WRITE -> SCAN ... -> DONE -> IDLE. busy=1 in SCAN through WRITE; done=1 only in DONE.
- Raster order: x advances fastest, from (0,0) to (max_x,max_y). WRITE advances the coordinate. After WRITE at (max_x,max_y) the FSM goes to DONE.
- SCAN (1 cycle):
  - A border pixel is one with x<3, y<3, x>max_x-3 or y>max_y-3. Border pixels go straight to WRITE with score 0, giving 2 cycles per pixel.
  - If max_x<6 or max_y<6, every pixel is border.
- FETCH (17 cycles): ren_rd=1 every cycle. Read 0 is the centre. Reads 1..16 are circle index i=0..15 at offsets (dx,dy):
  - i=0..7: (0,-3)(1,-3)(2,-2)(3,-1)(3,0)(3,1)(2,2)(1,3)
  - i=8..15: (0,3)(-1,3)(-2,2)(-3,1)(-3,0)(-3,-1)(-2,-2)(-1,-3)
- WAIT (1 cycle): captures the last read datum.
- EVAL (1 cycle):
  - Bright mask: b[i] = p[i] > c+t. Dark mask: d[i] = p[i]+t < c. Both are evaluated in PIXEL_DEPTH+1 bits, so there is no overflow.
  - A pixel is a corner if either mask contains a run of at least arc_len consecutive ones, treating index 15 as adjacent to index 0 (wrap-around).
  - If both the bright and dark conditions hold, bright wins.
- WRITE (1 cycle): wen_wr=1, address = current pixel, wdat_wr = score. corner_count increments when the score is nonzero.
- Cycle counts: an interior pixel takes 21 cycles (SCAN + 17 + WAIT + EVAL + WRITE). A border pixel takes 2 cycles.
- DONE (1 cycle): done=1, then IDLE. corner_count holds its value until the next start, which clears it to 0.
- Address outputs hold their last value when the corresponding enable is low.

Optional Feature:
FAST_SCORE_EN
- Defined: score = sum over the winning mask's set bits of (|p[i]-c| - t), saturated to 2^SCORE_DEPTH-1. A non-corner scores 0.
- Undefined: score = all ones (2^SCORE_DEPTH-1) for a corner and 0 otherwise. The adder tree is removed; timing and count are unchanged.

Test Plan:
- Flat 20x20 image (max_x=max_y=19, all pixels 80, t=10, arc_len=9) -> 400 writes, all 0. busy is high for 196*21+204*2 = 4524 cycles, then done pulses once and corner_count=0.
- 20x20 image with background 50 and (10,10)=200, t=20, arc_len=9 -> (10,10) scores 16*130=2080 with FAST_SCORE_EN (4095 without); every other pixel scores 0; corner_count=1.
- Centre 100, circle indices 12..15 and 0..4 at 160, rest at 100, t=20 -> with arc_len=9: corner, score 9*40=360 (wrap-around run). With arc_len=12: score 0.
- SCORE_DEPTH=10, centre 0, ring 255, t=0, arc_len=16 -> score saturates to 1023.
- Pulse n_rst low for 1 cycle during FETCH of pixel (5,5) -> next cycle busy=0, ren_rd=0, wen_wr=0, corner_count=0. A new start then rescans from (0,0).
- start held high during the frame, plus a max_x change mid-frame -> no restart, latched max_x is used, exactly one done pulse.
